// File: rtl/hwpe_stream_tcdm_rr_arbiter.sv
// hwpe_stream_tcdm_rr_arbiter
// Shares one TCDM master port between NB_IN HWPE requesters.
// Requests are selected round-robin through a combinational path. Every granted
// transaction is tracked in a fixed-latency pipeline so that r_valid is steered
// back to the requester that issued it.
// Optional feature: define HWPE_STREAM_ARB_BURST_LOCK_EN to let a requester keep
// the port for up to MAX_BURST consecutive grants.
module hwpe_stream_tcdm_rr_arbiter #(
    parameter int unsigned NB_IN        = 4,
    parameter int unsigned RESP_LATENCY = 1,
    parameter int unsigned MAX_BURST    = 4,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  clear_i,
    // requester ports
    input  logic [NB_IN-1:0]                      i_in_req,
    output logic [NB_IN-1:0]                      o_in_gnt,
    input  logic [NB_IN-1:0][ADDR_WIDTH-1:0]      i_in_add,
    input  logic [NB_IN-1:0]                      i_in_wen,
    input  logic [NB_IN-1:0][DATA_WIDTH/8-1:0]    i_in_be,
    input  logic [NB_IN-1:0][DATA_WIDTH-1:0]      i_in_data,
    output logic [NB_IN-1:0][DATA_WIDTH-1:0]      o_in_r_data,
    output logic [NB_IN-1:0]                      o_in_r_valid,
    // shared TCDM port
    output logic                                  o_out_req,
    input  logic                                  i_out_gnt,
    output logic [ADDR_WIDTH-1:0]                 o_out_add,
    output logic                                  o_out_wen,
    output logic [DATA_WIDTH/8-1:0]               o_out_be,
    output logic [DATA_WIDTH-1:0]                 o_out_data,
    input  logic [DATA_WIDTH-1:0]                 i_out_r_data,
    input  logic                                  i_out_r_valid,
    // sticky response-tracking error
    output logic                                  err_o
);

    localparam int unsigned PTR_W = (NB_IN > 1) ? $clog2(NB_IN) : 1;

    logic [PTR_W-1:0]                    r_ptr;
    logic [PTR_W-1:0]                    w_winner;
    logic [PTR_W-1:0]                    w_winner_inc;
    logic [PTR_W-1:0]                    w_ptr_next;
    logic                                w_found;
    logic                                w_hs;
    int unsigned                         w_scan_idx;
    logic [RESP_LATENCY-1:0]             r_pipe_valid;
    logic [RESP_LATENCY-1:0][PTR_W-1:0]  r_pipe_idx;
    logic                                w_tail_valid;
    logic [PTR_W-1:0]                    w_tail_idx;
    logic                                r_err;

    // Pick the first requester found scanning from the priority pointer upward, wrapping at NB_IN.
    always_comb begin
        w_winner   = r_ptr;
        w_found    = 1'b0;
        w_scan_idx = 0;
        for (int k = 0; k < int'(NB_IN); k++) begin
            w_scan_idx = (32'(r_ptr) + 32'(k)) % NB_IN;
            if (!w_found && i_in_req[w_scan_idx]) begin
                w_winner = PTR_W'(w_scan_idx);
                w_found  = 1'b1;
            end
        end
    end

    assign w_hs         = o_out_req & i_out_gnt;
    assign w_winner_inc = (w_winner == PTR_W'(NB_IN - 1)) ? '0 : w_winner + PTR_W'(1);

    // Steer the winner's request fields onto the shared port and return the grant only to it.
    always_comb begin
        o_out_req  = |i_in_req;
        o_out_add  = i_in_add[w_winner];
        o_out_wen  = i_in_wen[w_winner];
        o_out_be   = i_in_be[w_winner];
        o_out_data = i_in_data[w_winner];
        o_in_gnt   = '0;
        o_in_gnt[w_winner] = o_out_req & i_out_gnt;
    end

`ifdef HWPE_STREAM_ARB_BURST_LOCK_EN
    localparam int unsigned BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    logic [BCNT_W-1:0] r_bcnt;
    logic              w_burst_keep;

    assign w_burst_keep = i_in_req[w_winner] && ((32'(r_bcnt) + 32'd1) < MAX_BURST);
    assign w_ptr_next   = w_burst_keep ? w_winner : w_winner_inc;

    // Count consecutive grants of the current winner; restart once the burst ends or the winner goes idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bcnt <= '0;
        end else if (clear_i) begin
            r_bcnt <= '0;
        end else if (w_hs) begin
            r_bcnt <= w_burst_keep ? r_bcnt + BCNT_W'(1) : '0;
        end else if (!i_in_req[w_winner]) begin
            r_bcnt <= '0;
        end
    end
`else
    assign w_ptr_next = w_winner_inc;
`endif

    // Advance the priority pointer past the winner after each accepted request; a clear restarts at 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (clear_i) begin
            r_ptr <= '0;
        end else if (w_hs) begin
            r_ptr <= w_ptr_next;
        end
    end

    // Shift {valid, idx} of every cycle's grant down a non-stalling pipeline towards the response slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pipe_valid <= '0;
            r_pipe_idx   <= '0;
        end else begin
            r_pipe_idx[0] <= w_winner;
            for (int s = 1; s < int'(RESP_LATENCY); s++) begin
                r_pipe_idx[s] <= r_pipe_idx[s-1];
            end
            if (clear_i) begin
                r_pipe_valid <= '0;
            end else begin
                r_pipe_valid[0] <= w_hs;
                for (int s = 1; s < int'(RESP_LATENCY); s++) begin
                    r_pipe_valid[s] <= r_pipe_valid[s-1];
                end
            end
        end
    end

    assign w_tail_valid = r_pipe_valid[RESP_LATENCY-1];
    assign w_tail_idx   = r_pipe_idx[RESP_LATENCY-1];

    // Route a response only when it lines up with a tracked grant; data is broadcast to everyone.
    always_comb begin
        o_in_r_valid = '0;
        o_in_r_data  = '0;
        for (int i = 0; i < int'(NB_IN); i++) begin
            o_in_r_valid[i] = i_out_r_valid & w_tail_valid & (w_tail_idx == PTR_W'(i));
            o_in_r_data[i]  = i_out_r_data;
        end
    end

    // Latch an error whenever a response appears without a tracked grant or a tracked grant gets none.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (clear_i) begin
            r_err <= 1'b0;
        end else if (i_out_r_valid != w_tail_valid) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

endmodule

// File: tb/tb_hwpe_stream_tcdm_rr_arbiter.sv
// Testbench for hwpe_stream_tcdm_rr_arbiter.
// Two instances share the same requests: one with a 1-cycle and one with a 3-cycle
// response latency. A behavioural model predicts winners, grants and the sticky
// error; granted transactions go into per-instance scoreboards that also act as the
// memory returning responses, and a separate monitor checks routed responses.
module tb_hwpe_stream_tcdm_rr_arbiter;

    localparam int NB   = 4;
    localparam int MAXB = 4;

    typedef struct {
        int          idx;
        logic [31:0] data;
        int          due;
    } respT;

    logic clk = 1'b0;
    logic rst_ni;
    logic clear;

    logic [3:0]       inReq;
    logic [3:0][31:0] inAdd;
    logic [3:0]       inWen;
    logic [3:0][3:0]  inBe;
    logic [3:0][31:0] inData;
    logic             outGnt;
    logic             injectSpurious;

    logic [3:0]       gnt1, rValid1, gnt3, rValid3;
    logic [3:0][31:0] rData1, rData3;
    logic             req1, wen1, err1, req3, wen3, err3;
    logic [31:0]      add1, data1, add3, data3;
    logic [3:0]       be1, be3;
    logic             outRValid1, outRValid3;
    logic [31:0]      outRData1, outRData3;

    respT expQ1[$];
    respT expQ3[$];

    int cyc    = 0;
    int nTests = 0;
    int nFail  = 0;
    int mPtr   = 0;
    int mBcnt  = 0;
    bit mErr   = 1'b0;

    always #5 clk = ~clk;

    // Cycle index used to schedule responses.
    always @(posedge clk) cyc <= cyc + 1;

    hwpe_stream_tcdm_rr_arbiter #(.NB_IN(4), .RESP_LATENCY(1), .MAX_BURST(MAXB)) dut1 (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear),
        .i_in_req(inReq), .o_in_gnt(gnt1), .i_in_add(inAdd), .i_in_wen(inWen),
        .i_in_be(inBe), .i_in_data(inData), .o_in_r_data(rData1), .o_in_r_valid(rValid1),
        .o_out_req(req1), .i_out_gnt(outGnt), .o_out_add(add1), .o_out_wen(wen1),
        .o_out_be(be1), .o_out_data(data1), .i_out_r_data(outRData1),
        .i_out_r_valid(outRValid1), .err_o(err1)
    );

    hwpe_stream_tcdm_rr_arbiter #(.NB_IN(4), .RESP_LATENCY(3), .MAX_BURST(MAXB)) dut3 (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear),
        .i_in_req(inReq), .o_in_gnt(gnt3), .i_in_add(inAdd), .i_in_wen(inWen),
        .i_in_be(inBe), .i_in_data(inData), .o_in_r_data(rData3), .o_in_r_valid(rValid3),
        .o_out_req(req3), .i_out_gnt(outGnt), .o_out_add(add3), .o_out_wen(wen3),
        .o_out_be(be3), .o_out_data(data3), .i_out_r_data(outRData3),
        .i_out_r_valid(outRValid3), .err_o(err3)
    );

    task automatic checkEq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Winner rule: first requesting index scanning from the pointer, modulo NB.
    function automatic int modelWinner(input logic [3:0] r);
        for (int k = 0; k < NB; k++) begin
            if (r[(mPtr + k) % NB]) return (mPtr + k) % NB;
        end
        return -1;
    endfunction

    // Compare the request path against the model, then advance the model by one cycle.
    task automatic checkOutput(output logic [3:0] seen);
        int         w;
        int         sel;
        bit         hs;
        logic [3:0] expG;
        logic [31:0] rd;
        w    = modelWinner(inReq);
        sel  = (w >= 0) ? w : mPtr;
        hs   = (w >= 0) && outGnt;
        expG = hs ? 4'(1 << w) : 4'b0;
        checkEq("lat1 out_req", 32'(req1), 32'(|inReq));
        checkEq("lat1 in_gnt", 32'(gnt1), 32'(expG));
        checkEq("lat1 out_add", add1, inAdd[sel]);
        checkEq("lat1 out_data", data1, inData[sel]);
        checkEq("lat1 out_be_wen", {27'b0, be1, wen1}, {27'b0, inBe[sel], inWen[sel]});
        checkEq("lat1 err", 32'(err1), 32'(mErr));
        checkEq("lat3 out_req", 32'(req3), 32'(|inReq));
        checkEq("lat3 in_gnt", 32'(gnt3), 32'(expG));
        checkEq("lat3 out_add", add3, inAdd[sel]);
        checkEq("lat3 err", 32'(err3), 32'(mErr));
        seen = gnt1;
        if (clear) begin
            mPtr  = 0;
            mBcnt = 0;
            mErr  = 1'b0;
        end else begin
            if (injectSpurious) mErr = 1'b1;
            if (hs) begin
                rd = $urandom;
                expQ1.push_back('{idx: w, data: rd, due: cyc + 1});
                expQ3.push_back('{idx: w, data: rd, due: cyc + 3});
`ifdef HWPE_STREAM_ARB_BURST_LOCK_EN
                if (mBcnt < MAXB - 1) begin
                    mPtr  = w;
                    mBcnt = mBcnt + 1;
                end else begin
                    mPtr  = (w + 1) % NB;
                    mBcnt = 0;
                end
`else
                mPtr = (w + 1) % NB;
`endif
            end else if (w < 0) begin
                mBcnt = 0;
            end
        end
    endtask

    // Drive one cycle of inputs with fresh random payloads and check it mid-cycle.
    task automatic applyStimulus(input logic [3:0] r, input logic g, input logic clr,
                                 input logic spur, output logic [3:0] seen);
        inReq          = r;
        outGnt         = g;
        clear          = clr;
        injectSpurious = spur;
        for (int i = 0; i < NB; i++) begin
            inAdd[i]  = $urandom;
            inWen[i]  = 1'($urandom);
            inBe[i]   = 4'($urandom);
            inData[i] = $urandom;
        end
        @(negedge clk);
        checkOutput(seen);
        @(posedge clk);
        #1;
    endtask

    task automatic checkResp(input string nm, input logic [3:0] rv, input logic [3:0][31:0] rd,
                             input bit have, input respT f, output bit pop);
        nTests++;
        pop = have;
        if (have) begin
            if (rv !== 4'(1 << f.idx) || rd[f.idx] !== f.data) begin
                nFail++;
                $display("[TB] FAIL %s response: r_valid %b data %h, expected r_valid %b data %h (cycle %0d)",
                         nm, rv, rd[f.idx], 4'(1 << f.idx), f.data, cyc);
            end
        end else if (rv !== 4'b0) begin
            nFail++;
            $display("[TB] FAIL %s stray response: r_valid %b, expected 0000 (cycle %0d)", nm, rv, cyc);
        end
    endtask

    // Memory side: return each scoreboard entry on its due cycle, or a stray response on request.
    initial begin : memory
        outRValid1 = 1'b0;
        outRValid3 = 1'b0;
        outRData1  = '0;
        outRData3  = '0;
        forever begin
            @(posedge clk);
            #2;
            outRValid1 = injectSpurious;
            outRData1  = $urandom;
            if (expQ1.size() > 0) begin
                if (expQ1[0].due == cyc) begin
                    outRValid1 = 1'b1;
                    outRData1  = expQ1[0].data;
                end
            end
            outRValid3 = injectSpurious;
            outRData3  = $urandom;
            if (expQ3.size() > 0) begin
                if (expQ3[0].due == cyc) begin
                    outRValid3 = 1'b1;
                    outRData3  = expQ3[0].data;
                end
            end
        end
    end

    // Monitor: pop the scoreboard whenever a response is due and compare what the DUTs route.
    initial begin : monitor
        respT f;
        bit   have;
        bit   pop;
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                have = 1'b0;
                f    = '{idx: 0, data: 32'h0, due: 0};
                if (expQ1.size() > 0) begin
                    if (expQ1[0].due == cyc) begin
                        have = 1'b1;
                        f    = expQ1[0];
                    end
                end
                checkResp("lat1", rValid1, rData1, have, f, pop);
                if (pop) void'(expQ1.pop_front());
                have = 1'b0;
                f    = '{idx: 0, data: 32'h0, due: 0};
                if (expQ3.size() > 0) begin
                    if (expQ3[0].due == cyc) begin
                        have = 1'b1;
                        f    = expQ3[0];
                    end
                end
                checkResp("lat3", rValid3, rData3, have, f, pop);
                if (pop) void'(expQ3.pop_front());
            end
        end
    end

    // Directed scenarios followed by a randomized run, then drain and summarize.
    initial begin : stimulus
        logic [3:0] seen;
        rst_ni         = 1'b0;
        clear          = 1'b0;
        inReq          = '0;
        inAdd          = '0;
        inWen          = '0;
        inBe           = '0;
        inData         = '0;
        outGnt         = 1'b1;
        injectSpurious = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkEq("reset out_req", 32'(req1), 32'd0);
        checkEq("reset in_gnt", 32'(gnt1), 32'd0);
        checkEq("reset r_valid", {28'b0, rValid1}, 32'd0);
        checkEq("reset err", {30'b0, err3, err1}, 32'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Lone requester 3 from pointer 0, then lone requester 0.
        applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0, seen);
        checkEq("lone req3 grant", 32'(seen), 32'h8);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, seen);
        checkEq("lone req0 grant", 32'(seen), 32'h1);
        repeat (4) applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, seen);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, seen);

        // All four requesting continuously.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, seen);
`ifdef HWPE_STREAM_ARB_BURST_LOCK_EN
            checkEq("all-req burst order", 32'(seen), 32'(1 << ((i / 4) % 4)));
`else
            checkEq("all-req rr order", 32'(seen), 32'(1 << (i % 4)));
`endif
        end

        // Requesters 1 and 2 stalled by the shared port, then released.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0, seen);
            checkEq("stalled no grant", 32'(seen), 32'h0);
        end
        applyStimulus(4'b0110, 1'b1, 1'b0, 1'b0, seen);
`ifndef HWPE_STREAM_ARB_BURST_LOCK_EN
        checkEq("released first grant", 32'(seen), 32'h2);
`endif
        applyStimulus(4'b0110, 1'b1, 1'b0, 1'b0, seen);
`ifndef HWPE_STREAM_ARB_BURST_LOCK_EN
        checkEq("released second grant", 32'(seen), 32'h4);
`endif

        // Two continuous requesters.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b0011, 1'b1, 1'b0, 1'b0, seen);
`ifndef HWPE_STREAM_ARB_BURST_LOCK_EN
            checkEq("ping-pong order", 32'(seen), 32'(1 << (i % 2)));
`endif
        end

        // Stray response with nothing in flight, then clear.
        repeat (4) applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, seen);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, seen);
        repeat (2) applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, seen);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, seen);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, seen);

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(4'($urandom), 1'(($urandom % 4) != 0), 1'b0, 1'b0, seen);
        end

        repeat (6) applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, seen);
        checkEq("lat1 responses drained", 32'(expQ1.size()), 32'd0);
        checkEq("lat3 responses drained", 32'(expQ3.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_tcdm_rr_arbiter.md
# hwpe_stream_tcdm_rr_arbiter

Shares a single TCDM master port between `NB_IN` HWPE requesters, typically several sinks and sources of one accelerator that would otherwise each need a dedicated TCDM port. Request selection is round-robin, and the request path is combinational. Each granted transaction is tracked in a fixed-latency response pipeline so that `r_valid` returns to the requester that issued it.

## Interface
Parameters:
- `NB_IN`, default 4: number of requester ports (≥1).
- `RESP_LATENCY`, default 1: cycles from grant to `r_valid` on the shared port (≥1).
- `MAX_BURST`, default 4: maximum consecutive grants per requester when burst lock is compiled in (≥1).

Ports:
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `clear_i`  in  1: synchronous soft clear.
- `in_tcdm[NB_IN-1:0]`  `hwpe_stream_intf_tcdm.slave`: requester ports (`req`, `gnt`, `add`, `wen`, `be`, `data`, `r_data`, `r_valid`).
- `out_tcdm`  `hwpe_stream_intf_tcdm.master`: shared TCDM port.
- `err_o`  out  1: sticky response-tracking error.

## Operation
- **Priority pointer.** `ptr` has width `max(1,$clog2(NB_IN))`. The winner `w` is the first index with `in_tcdm[i].req=1` scanning `ptr`, `ptr+1`, … modulo `NB_IN`.
- **Request path.**
  - `out_tcdm.req = |in_tcdm[*].req`.
  - `add`, `wen`, `be`, `data` are muxed from `w`.
  - `in_tcdm[w].gnt = out_tcdm.gnt`; every other `gnt` is 0.
  - With no request, the muxed fields come from index `ptr`, and `out_tcdm.req=0`.
- **Handshake.** A handshake is `out_tcdm.req & out_tcdm.gnt`.
  - On a handshake, `ptr <= (w+1) mod NB_IN`.
  - Without a handshake, `ptr` holds. A newly arriving higher-priority request may displace the pending winner, which is legal TCDM behaviour because no `gnt` was given.
- **Response pipeline.** The pipeline has `RESP_LATENCY` stages of `{valid, idx}`.
  - Stage 0 loads `{handshake, w}` every cycle.
  - Stages shift every cycle and never stall.
  - Every granted transaction, read or write, expects exactly one `out_tcdm.r_valid` when it reaches the tail stage.
- **Response routing.**
  - `in_tcdm[i].r_valid = out_tcdm.r_valid & tail.valid & (tail.idx==i)`.
  - `in_tcdm[i].r_data = out_tcdm.r_data` (broadcast to all requesters).
- **Error.** `err_o` sets, and stays set, when `out_tcdm.r_valid != tail.valid` in any cycle. The mismatched response is dropped; it is not routed.
- **Clear.** `clear_i` sets `ptr` to 0, flushes all pipeline valids, zeroes the burst counter and clears `err_o`. `clear_i` may be asserted only while no response is in flight. A response arriving after a clear is flagged as an error.
- **Degenerate case.** With `NB_IN=1` the block is a pass-through plus response tracking.

## Timing
- Request path: combinational, 0 cycles from `in.req` to `out.req` / `in.gnt`.
- Response path: `in.r_valid` is combinational from `out.r_valid`. It therefore asserts exactly `RESP_LATENCY` cycles after the grant cycle.
- Reset values: `ptr=0`, pipeline empty, burst counter 0, `err_o=0`. Consequently every `in_tcdm.r_valid` is 0 and `out_tcdm.req` is 0 unless some `in.req` is 1.
- Simultaneous events:
  - A handshake and a tail response in the same cycle are both processed.
  - `clear_i` takes priority over the handshake update of `ptr`, pipeline and counter. The shared-port grant itself still occurs.
- Reset mid-operation: all state is lost immediately. Outstanding responses are not routed.

## Configuration
- Macro: `HWPE_STREAM_ARB_BURST_LOCK_EN`.
- **Defined.** A burst counter `bcnt` is added.
  - On a handshake by `w`: if `in_tcdm[w].req` was high this cycle and `bcnt < MAX_BURST-1`, then `ptr <= w` and `bcnt++`.
  - Otherwise `ptr <= w+1` and `bcnt <= 0`.
  - A cycle in which `w` does not request resets `bcnt`.
- **Undefined.** Pure round-robin; `bcnt` and `MAX_BURST` are unused.

## Test plan
Unless stated otherwise: `NB_IN=4`, `RESP_LATENCY=1`, `out.gnt` tied high, macro undefined, and the bench returns `r_valid` one cycle after each grant.

1. All four requesters hold `req=1` → grants go to 0,1,2,3,0,1… one per cycle. Each `in[i].r_valid` pulses 1 cycle after its grant carrying `r_data`, and `err_o` stays 0.
2. `in[1]` and `in[2]` request, `out.gnt=0` for 3 cycles → no `in.gnt`, `out.add` equals `in[1].add`, `ptr` stays 0. When `gnt` returns, `in[1].gnt=1`, then `in[2].gnt=1` on the next cycle.
3. Only `in[3]` requests with `ptr=0` → `in[3]` is granted and `ptr` wraps to 0. A second single request from `in[0]` is granted immediately.
4. The bench asserts `out.r_valid` with no pending grant → `err_o=1` from the next cycle and no `in.r_valid` pulses. `err_o` holds until a `clear_i` pulse returns it to 0.
5. Macro defined, `MAX_BURST=4`, `in[0]` and `in[1]` requesting continuously → grant order 0,0,0,0,1,1,1,1,0,… With the macro undefined the order is 0,1,0,1,…
6. `RESP_LATENCY=3` with back-to-back grants to 2,0,1 → `r_valid` appears on 2,0,1 in cycles t+3, t+4, t+5 respectively, and `err_o=0`.
